// File: rtl/draw_sequencer_if.sv
// Request and datapath-control bundle between a draw client and draw_sequencer.
// The client owns the request fields; the sequencer owns every strobe and select.
interface draw_sequencer_if;
  logic       req;
  logic       reqSprite;
  logic       reqBlack;
  logic [4:0] reqImage;
  logic [3:0] reqXSel;
  logic [1:0] reqYSel;

  logic       xInitLoad;
  logic       yInitLoad;
  logic       xReset;
  logic       yReset;
  logic       xCountUp;
  logic       yCountUp;
  logic       addressScreenCounterReset;
  logic       screenCountLoad;
  logic       addressSpriteCounterReset;
  logic       spriteCountLoad;

  logic [3:0] xInitSel;
  logic [1:0] yInitSel;
  logic [1:0] xySel;
  logic [4:0] memorySel;
  logic       black;

  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output req, reqSprite, reqBlack, reqImage, reqXSel, reqYSel,
    input  xInitLoad, yInitLoad, xReset, yReset, xCountUp, yCountUp,
    input  addressScreenCounterReset, screenCountLoad,
    input  addressSpriteCounterReset, spriteCountLoad,
    input  xInitSel, yInitSel, xySel, memorySel, black,
    input  plot, busy, done
  );

  modport slave (
    input  req, reqSprite, reqBlack, reqImage, reqXSel, reqYSel,
    output xInitLoad, yInitLoad, xReset, yReset, xCountUp, yCountUp,
    output addressScreenCounterReset, screenCountLoad,
    output addressSpriteCounterReset, spriteCountLoad,
    output xInitSel, yInitSel, xySel, memorySel, black,
    output plot, busy, done
  );
endinterface

// File: rtl/draw_sequencer.sv
// Walks a full-screen or sprite rectangle one pixel per cycle, issuing datapath
// strobes and a ROM-latency-aligned plot enable; done pulses once per finished job.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40
) (
  input  logic             clk,
  input  logic             reset,
  draw_sequencer_if.slave  bus
);

  localparam int MAX_W  = (SCREEN_W > SPRITE_W) ? SCREEN_W : SPRITE_W;
  localparam int MAX_H  = (SCREEN_H > SPRITE_H) ? SCREEN_H : SPRITE_H;
  localparam int MAX_WH = (MAX_W > MAX_H) ? MAX_W : MAX_H;
  localparam int CW     = (MAX_WH > 1) ? $clog2(MAX_WH) : 1;

  localparam logic [CW-1:0] SCR_W_LAST = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] SCR_H_LAST = CW'(SCREEN_H - 1);
  localparam logic [CW-1:0] SPR_W_LAST = CW'(SPRITE_W - 1);
  localparam logic [CW-1:0] SPR_H_LAST = CW'(SPRITE_H - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, FLUSH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;

  logic          job_sprite;
  logic          job_black;
  logic [4:0]    job_image;
  logic [3:0]    job_xsel;
  logic [1:0]    job_ysel;

  logic          x_init_load, y_init_load, x_reset, y_reset;
  logic          x_count_up, y_count_up;
  logic          scr_cnt_reset, scr_cnt_load, spr_cnt_reset, spr_cnt_load;
  logic          plot, busy, done;

  logic [CW-1:0] w_last, h_last, col_nxt;
  logic          col_last, row_last;

  always_comb begin
    w_last   = job_sprite ? SPR_W_LAST : SCR_W_LAST;
    h_last   = job_sprite ? SPR_H_LAST : SCR_H_LAST;
    col_last = (col == w_last);
    row_last = (row == h_last);
    col_nxt  = col_last ? '0 : col + CW'(1);
  end

  // Every output is a register set one edge ahead, so strobes for the DRAW
  // cycle at (col,row) are decided from the address that cycle will hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      job_sprite    <= 1'b0;
      job_black     <= 1'b0;
      job_image     <= '0;
      job_xsel      <= '0;
      job_ysel      <= '0;
      x_init_load   <= 1'b0;
      y_init_load   <= 1'b0;
      x_reset       <= 1'b0;
      y_reset       <= 1'b0;
      x_count_up    <= 1'b0;
      y_count_up    <= 1'b0;
      scr_cnt_reset <= 1'b0;
      scr_cnt_load  <= 1'b0;
      spr_cnt_reset <= 1'b0;
      spr_cnt_load  <= 1'b0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle and are re-asserted only where
      // needed; non-blocking assignments keep every register sampling old state.
      x_init_load   <= 1'b0;
      y_init_load   <= 1'b0;
      x_reset       <= 1'b0;
      y_reset       <= 1'b0;
      x_count_up    <= 1'b0;
      y_count_up    <= 1'b0;
      scr_cnt_reset <= 1'b0;
      scr_cnt_load  <= 1'b0;
      spr_cnt_reset <= 1'b0;
      spr_cnt_load  <= 1'b0;
      done          <= 1'b0;
      plot          <= (state == DRAW);

      case (state)
        IDLE: begin
          if (bus.req) begin
            job_sprite    <= bus.reqSprite;
            job_black     <= bus.reqBlack;
            job_image     <= bus.reqImage;
            job_xsel      <= bus.reqXSel;
            job_ysel      <= bus.reqYSel;
            state         <= LOAD;
            busy          <= 1'b1;
            x_reset       <= 1'b1;
            y_reset       <= 1'b1;
            x_init_load   <= bus.reqSprite;
            y_init_load   <= bus.reqSprite;
            spr_cnt_reset <= bus.reqSprite;
            scr_cnt_reset <= ~bus.reqSprite;
          end
        end

        LOAD: begin
          state        <= DRAW;
          col          <= '0;
          row          <= '0;
          spr_cnt_load <= job_sprite;
          scr_cnt_load <= ~job_sprite;
          x_count_up   <= (w_last != '0);
          y_count_up   <= (w_last == '0);
        end

        DRAW: begin
          col <= col_nxt;
          if (col_last) row <= row_last ? '0 : row + CW'(1);
          if (col_last && row_last) begin
            state <= FLUSH;
          end else begin
            spr_cnt_load <= job_sprite;
            scr_cnt_load <= ~job_sprite;
            x_count_up   <= (col_nxt != w_last);
            y_count_up   <= (col_nxt == w_last);
          end
        end

        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.xInitLoad                 = x_init_load;
  assign bus.yInitLoad                 = y_init_load;
  assign bus.xReset                    = x_reset;
  assign bus.yReset                    = y_reset;
  assign bus.xCountUp                  = x_count_up;
  assign bus.yCountUp                  = y_count_up;
  assign bus.addressScreenCounterReset = scr_cnt_reset;
  assign bus.screenCountLoad           = scr_cnt_load;
  assign bus.addressSpriteCounterReset = spr_cnt_reset;
  assign bus.spriteCountLoad           = spr_cnt_load;
  assign bus.xInitSel                  = job_xsel;
  assign bus.yInitSel                  = job_ysel;
  assign bus.xySel                     = {1'b0, job_sprite};
  assign bus.memorySel                 = job_image;
  assign bus.black                     = job_black;
  assign bus.plot                      = plot;
  assign bus.busy                      = busy;
  assign bus.done                      = done;

endmodule
